mini_src_control_unit: RTL and testbench

- Hardwired control sequencer for the Mini SRC datapath.
- Steps the fetch, decode and execute T-states and drives every bus-driver, register-load and memory strobe the datapath consumes.
- Reads the instruction from the IR output.
- Register-field strobes (Gra/Grb/Grc, Rin, Rout, BAout) feed the existing select/encode logic.

---
 rtl/mini_src_control_unit.sv | 137 +++++++++++++
 tb/tb_mini_src_control_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mini_src_control_unit.sv
// mini_src_control_unit: hardwired fetch/decode/execute sequencer for the Mini SRC datapath.
// Strobes are decoded from the registered T-state and forced low while clear is high.
module mini_src_control_unit #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zloout,
    output logic        Zhiout,
    output logic        MDRout,
    output logic        Cout,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        HI_in,
    output logic        LO_in,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [3:0]  alu_op,
    output logic        running,
    output logic        illegal_op,
    output logic        bus_error
);
    typedef enum logic [3:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_illegal, r_bus_error;

    logic [4:0] w_op;
    logic       w_rt, w_im, w_md, w_ld, w_st, w_ls, w_nop, w_hlt, w_ill;
    logic       w_wait, w_tmo, w_act;
    logic       w_t0, w_t1, w_t2, w_t3, w_t4, w_t5, w_t6, w_t7;
    logic [3:0] w_alu;
    logic       w_unused;

    assign w_op     = IR[31:27];
    assign w_unused = ^IR[26:0];
    assign w_rt     = w_op[4:3] == 2'b00;
    assign w_im     = w_op == 5'b01000 || w_op == 5'b01001 || w_op == 5'b01010;
    assign w_ld     = w_op == 5'b01011;
    assign w_st     = w_op == 5'b01100;
    assign w_md     = w_op == 5'b01101 || w_op == 5'b01110;
    assign w_nop    = w_op == 5'b11010;
    assign w_hlt    = w_op == 5'b11011;
    assign w_ls     = w_ld | w_st;
    assign w_ill    = !(w_rt | w_im | w_ls | w_md | w_nop | w_hlt);

    // Memory wait states; a timeout is the cycle whose miss would bring the count to MEM_WAIT_MAX
    assign w_wait = r_state == S_T1 || (r_state == S_T6 && w_ld) || (r_state == S_T7 && w_st);
    assign w_tmo  = w_wait && !mem_ready && r_cnt == 4'(MEM_WAIT_MAX - 1);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state     <= S_T0;
            r_cnt       <= 4'd0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_cnt <= (w_wait && !mem_ready) ? r_cnt + 4'd1 : 4'd0;
            if (w_tmo) begin
                r_bus_error <= 1'b1;
                r_state     <= S_HALT;
            end else begin
                case (r_state)
                    S_T0: r_state <= S_T1;
                    S_T1: r_state <= mem_ready ? S_T2 : S_T1;
                    S_T2: r_state <= S_T3;
                    S_T3: begin
                        r_state <= (w_ill || w_hlt) ? S_HALT : w_nop ? S_T0 : S_T4;
                        if (w_ill) r_illegal <= 1'b1;
                    end
                    S_T4: r_state <= S_T5;
                    S_T5: r_state <= (w_rt || w_im) ? S_T0 : S_T6;
                    S_T6: r_state <= w_md ? S_T0 : (w_st || mem_ready) ? S_T7 : S_T6;
                    S_T7: r_state <= (w_ld || mem_ready) ? S_T0 : S_T7;
                    default: r_state <= S_HALT;
                endcase
            end
        end
    end

    assign w_act = !clear;
    assign w_t0  = w_act && r_state == S_T0;
    assign w_t1  = w_act && r_state == S_T1;
    assign w_t2  = w_act && r_state == S_T2;
    assign w_t3  = w_act && r_state == S_T3;
    assign w_t4  = w_act && r_state == S_T4;
    assign w_t5  = w_act && r_state == S_T5;
    assign w_t6  = w_act && r_state == S_T6;
    assign w_t7  = w_act && r_state == S_T7;

    assign PCout  = w_t0;
    assign IncPC  = w_t0;
    assign MAR_in = w_t0 | (w_t5 & w_ls);
    assign Read   = w_t1 | (w_t6 & w_ld);
    assign MDR_in = ((w_t1 | (w_t6 & w_ld)) & mem_ready) | (w_t6 & w_st);
    assign MDRout = w_t2 | (w_t7 & w_ld);
    assign IR_in  = w_t2;
    assign Y_in   = w_t3 & (w_rt | w_im | w_md | w_ls);
    assign BAout  = w_t3 & w_ls;
    assign Rout   = (w_t3 & (w_rt | w_im | w_md)) | (w_t4 & (w_rt | w_md)) | (w_t6 & w_st);
    assign Gra    = (w_t3 & w_md) | (w_t5 & (w_rt | w_im)) | (w_t6 & w_st) | (w_t7 & w_ld);
    assign Grb    = (w_t3 & (w_rt | w_im | w_ls)) | (w_t4 & w_md);
    assign Grc    = w_t4 & w_rt;
    assign Z_in   = w_t4 & (w_rt | w_im | w_md | w_ls);
    assign Cout   = w_t4 & (w_im | w_ls);
    assign Zloout = w_t5 & (w_rt | w_im | w_md | w_ls);
    assign Rin    = (w_t5 & (w_rt | w_im)) | (w_t7 & w_ld);
    assign LO_in  = w_t5 & w_md;
    assign Zhiout = w_t6 & w_md;
    assign HI_in  = w_t6 & w_md;
    assign Write  = w_t7 & w_st;

    assign w_alu = w_rt ? {1'b0, w_op[2:0]} :
                   w_op == 5'b01001 ? 4'b0010 :
                   w_op == 5'b01010 ? 4'b0011 :
                   w_op == 5'b01101 ? 4'b1000 :
                   w_op == 5'b01110 ? 4'b1001 : 4'b0000;
    assign alu_op = (w_t3 | w_t4 | w_t5 | w_t6 | w_t7) ? w_alu : 4'b0000;

    assign running    = w_act && r_state != S_HALT;
    assign illegal_op = r_illegal;
    assign bus_error  = r_bus_error;
endmodule

// File: tb/tb_mini_src_control_unit.sv
// tb_mini_src_control_unit: directed cycle-by-cycle checks of the Mini SRC control sequencer.
module tb_mini_src_control_unit;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'h0;
    logic        mem_ready = 1'b0;
    logic PCout, Zloout, Zhiout, MDRout, Cout, MAR_in, MDR_in, IR_in, Y_in, Z_in, HI_in, LO_in;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, running, illegal_op, bus_error;
    logic [3:0]  alu_op;
    logic [20:0] sig;
    logic [2:0]  flg;
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [20:0] PCO = 21'h100000, ZLO = 21'h080000, ZHO = 21'h040000, MDRO = 21'h020000;
    localparam logic [20:0] CO  = 21'h010000, RO  = 21'h008000, BAO = 21'h004000, MARI = 21'h002000;
    localparam logic [20:0] MDRI = 21'h001000, IRI = 21'h000800, YI = 21'h000400, ZI = 21'h000200;
    localparam logic [20:0] HII = 21'h000100, LOI = 21'h000080, INC = 21'h000040, RD = 21'h000020;
    localparam logic [20:0] WR  = 21'h000010, GRA = 21'h000008, GRB = 21'h000004, GRC = 21'h000002;
    localparam logic [20:0] RIN = 21'h000001;
    localparam logic [2:0]  OK = 3'b100;

    mini_src_control_unit #(.MEM_WAIT_MAX(15)) dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .Zloout(Zloout), .Zhiout(Zhiout), .MDRout(MDRout), .Cout(Cout),
        .MAR_in(MAR_in), .MDR_in(MDR_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
        .HI_in(HI_in), .LO_in(LO_in), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .running(running), .illegal_op(illegal_op), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    assign sig = {PCout, Zloout, Zhiout, MDRout, Cout, Rout, BAout, MAR_in, MDR_in, IR_in, Y_in,
                  Z_in, HI_in, LO_in, IncPC, Read, Write, Gra, Grb, Grc, Rin};
    assign flg = {running, illegal_op, bus_error};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge: drive mem_ready, check the current state, advance one cycle
    task automatic step(input string tag, input logic rdy, input logic [20:0] es,
                        input logic [3:0] ea, input logic [2:0] ef);
        mem_ready = rdy;
        #1;
        check({tag, "/sig"}, 32'(sig), 32'(es));
        check({tag, "/alu"}, 32'(alu_op), 32'(ea));
        check({tag, "/flg"}, 32'(flg), 32'(ef));
        @(negedge clock);
    endtask

    task automatic fetch(input logic [31:0] ir, input int waits);
        IR = ir;
        step("T0", 1'b0, PCO | MARI | INC, 4'h0, OK);
        for (int i = 0; i < waits; i++) step("T1w", 1'b0, RD, 4'h0, OK);
        step("T1", 1'b1, RD | MDRI, 4'h0, OK);
        step("T2", 1'b0, MDRO | IRI, 4'h0, OK);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("clr/sig", 32'(sig), 32'h0);
        check("clr/flg", 32'(flg), 32'h0);
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        #1;
        check("rst/sig", 32'(sig), 32'h0);
        check("rst/alu", 32'(alu_op), 32'h0);
        check("rst/flg", 32'(flg), 32'h0);
        clear = 1'b0;
        // add R1,R2,R3
        fetch(32'h00918000, 0);
        step("add3", 1'b0, GRB | RO | YI, 4'h0, OK);
        step("add4", 1'b0, GRC | RO | ZI, 4'h0, OK);
        step("add5", 1'b0, ZLO | GRA | RIN, 4'h0, OK);
        // rol
        fetch(32'h38000000, 0);
        step("rol3", 1'b0, GRB | RO | YI, 4'h7, OK);
        step("rol4", 1'b0, GRC | RO | ZI, 4'h7, OK);
        step("rol5", 1'b0, ZLO | GRA | RIN, 4'h7, OK);
        // mul with three wait cycles in fetch
        fetch(32'h68000000, 3);
        step("mul3", 1'b0, GRA | RO | YI, 4'h8, OK);
        step("mul4", 1'b0, GRB | RO | ZI, 4'h8, OK);
        step("mul5", 1'b0, ZLO | LOI, 4'h8, OK);
        step("mul6", 1'b0, ZHO | HII, 4'h8, OK);
        // ori
        fetch(32'h50000000, 0);
        step("ori3", 1'b0, GRB | RO | YI, 4'h3, OK);
        step("ori4", 1'b0, CO | ZI, 4'h3, OK);
        step("ori5", 1'b0, ZLO | GRA | RIN, 4'h3, OK);
        // ld with two data waits
        fetch(32'h58000000, 0);
        step("ld3", 1'b0, GRB | BAO | YI, 4'h0, OK);
        step("ld4", 1'b0, CO | ZI, 4'h0, OK);
        step("ld5", 1'b0, ZLO | MARI, 4'h0, OK);
        step("ld6a", 1'b0, RD, 4'h0, OK);
        step("ld6b", 1'b0, RD, 4'h0, OK);
        step("ld6c", 1'b1, RD | MDRI, 4'h0, OK);
        step("ld7", 1'b0, MDRO | GRA | RIN, 4'h0, OK);
        // st with one write wait
        fetch(32'h60000000, 0);
        step("st3", 1'b0, GRB | BAO | YI, 4'h0, OK);
        step("st4", 1'b0, CO | ZI, 4'h0, OK);
        step("st5", 1'b0, ZLO | MARI, 4'h0, OK);
        step("st6", 1'b0, GRA | RO | MDRI, 4'h0, OK);
        step("st7a", 1'b0, WR, 4'h0, OK);
        step("st7b", 1'b1, WR, 4'h0, OK);
        // nop whose fetch succeeds on the last allowed wait cycle
        fetch(32'hD0000000, 14);
        step("nop3", 1'b0, 21'h0, 4'h0, OK);
        // halt
        fetch(32'hD8000000, 0);
        step("hlt3", 1'b0, 21'h0, 4'h0, OK);
        for (int i = 0; i < 3; i++) step("hlt", 1'b1, 21'h0, 4'h0, 3'b000);
        do_clear();
        // undefined opcode
        fetch(32'hF8000000, 0);
        step("ill3", 1'b0, 21'h0, 4'h0, OK);
        for (int i = 0; i < 20; i++) step("ill", 1'b0, 21'h0, 4'h0, 3'b010);
        do_clear();
        // memory never responds during fetch
        IR = 32'h00918000;
        step("be0", 1'b0, PCO | MARI | INC, 4'h0, OK);
        for (int i = 0; i < 15; i++) step("be1", 1'b0, RD, 4'h0, OK);
        for (int i = 0; i < 3; i++) step("berr", 1'b1, 21'h0, 4'h0, 3'b001);
        do_clear();
        // clear asserted mid-cycle while st is writing
        fetch(32'h60000000, 0);
        step("cs3", 1'b0, GRB | BAO | YI, 4'h0, OK);
        step("cs4", 1'b0, CO | ZI, 4'h0, OK);
        step("cs5", 1'b0, ZLO | MARI, 4'h0, OK);
        step("cs6", 1'b0, GRA | RO | MDRI, 4'h0, OK);
        mem_ready = 1'b0;
        #1;
        check("cs7/wr", 32'(Write), 32'h1);
        clear = 1'b1;
        #1;
        check("cs7/clr", 32'(sig), 32'h0);
        @(negedge clock);
        clear = 1'b0;
        step("rs0", 1'b0, PCO | MARI | INC, 4'h0, OK);
        step("rs1", 1'b0, RD, 4'h0, OK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
